// File: rtl/uart_buf_pkg.sv
// Shared types for the UART output buffer: entry layout, drain states,
// control characters. Optional CRLF expansion: UART_OUT_CRLF_EN.
package uart_buf_pkg;

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef struct packed {
      logic [7:0] ch;
      logic       lf;
   } uart_entry_t;

   typedef enum logic {
      EMIT,
      CR
   } drain_state_t;

   function automatic uart_entry_t mk_entry(input logic [7:0] ch);
      uart_entry_t e;
      e.ch = ch;
      e.lf = (ch == CH_LF);
      return e;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers for full/empty detection.
// Head data is read straight from storage; push/pop are caller-qualified.
module sync_fifo #(
   parameter int  DEPTH   = 16,
   parameter type entry_t = logic [7:0]
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_push,
   input  entry_t                 i_data,
   input  logic                   i_pop,
   output entry_t                 o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr;
   logic [AW:0] r_rd;
   entry_t      r_mem [DEPTH];

   assign o_empty = (r_wr == r_rd);
   assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_level = r_wr - r_rd;
   assign o_head  = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + (AW+1)'(1);
         if (i_pop && !o_empty) r_rd <= r_rd + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_out_buffer.sv
// Buffers SimTop UART characters, tags line ends, counts drops and lines.
// Define UART_OUT_CRLF_EN to expand LF into a CR,LF beat pair.
module uart_out_buffer
   import uart_buf_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int IDLE_TIMEOUT = 1024,
   parameter int CNT_W        = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [7:0]             in_ch,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_ch,
   output logic                   out_last,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       drop_cnt,
   output logic [CNT_W-1:0]       line_cnt
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [TW-1:0] T_MAX = TW'(IDLE_TIMEOUT);

   uart_entry_t      w_head;
   logic             w_full;
   logic             w_empty;
   logic [LW-1:0]    w_level;
   logic             w_hs;
   logic             w_pop;
   logic             w_push;
   logic             w_one;
   logic             w_split;

   logic [TW-1:0]    r_timer;
   logic             r_force;
   logic [CNT_W-1:0] r_drop;
   logic [CNT_W-1:0] r_line;

   sync_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (uart_entry_t)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (mk_entry(in_ch)),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign out_valid = !w_empty;
   assign level     = w_level;
   assign drop_cnt  = r_drop;
   assign line_cnt  = r_line;
   assign w_one     = (w_level == LW'(1));
   assign w_hs      = out_valid && out_ready;
   assign w_pop     = w_hs && !w_split;
   assign w_push    = in_valid && (!w_full || w_pop);

`ifdef UART_OUT_CRLF_EN
   drain_state_t r_state;

   // An LF head first goes out as CR without leaving the FIFO
   assign w_split = w_head.lf && (r_state == EMIT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= EMIT;
      end else begin
         unique case (r_state)
            EMIT: if (w_hs && w_head.lf) r_state <= CR;
            CR:   if (w_hs) r_state <= EMIT;
         endcase
      end
   end
`else
   assign w_split = 1'b0;
`endif

   always_comb begin
      out_ch   = 8'h00;
      out_last = 1'b0;
      if (out_valid) begin
         out_ch   = w_split ? CH_CR : w_head.ch;
         out_last = !w_split && (w_head.lf || (r_force && w_one));
      end
   end

   // force_last belongs to the newest entry; it dies with a push or its pop
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
         r_force <= 1'b0;
      end else if (w_push) begin
         r_timer <= '0;
         r_force <= 1'b0;
      end else begin
         if (w_pop && w_one) r_force <= 1'b0;
         if (w_empty) begin
            r_timer <= '0;
         end else if (r_timer != T_MAX) begin
            r_timer <= r_timer + TW'(1);
            if (r_timer == T_MAX - TW'(1)) r_force <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_drop <= '0;
         r_line <= '0;
      end else begin
         if (in_valid && !w_push && !(&r_drop))
            r_drop <= r_drop + CNT_W'(1);
         if (w_hs && out_last && !(&r_line))
            r_line <= r_line + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_out_buffer.sv
// Directed bench for uart_out_buffer with a queue-based reference model.
// Honours UART_OUT_CRLF_EN to match the DUT build.
module tb_uart_out_buffer;

   localparam int DEPTH = 16;
   localparam int TO    = 8;
   localparam int CW    = 3;
   localparam int SAT   = (1 << CW) - 1;
`ifdef UART_OUT_CRLF_EN
   localparam bit CRLF  = 1'b1;
`else
   localparam bit CRLF  = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_ch = 8'h00;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [7:0]        out_ch;
   logic              out_last;
   logic [$clog2(DEPTH):0] level;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     line_cnt;

   int checks = 0;
   int passes = 0;

   uart_out_buffer #(
      .DEPTH        (DEPTH),
      .IDLE_TIMEOUT (TO),
      .CNT_W        (CW)
   ) dut (
      .clock     (clk),
      .reset     (rst_n),
      .in_valid  (in_valid),
      .in_ch     (in_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_last  (out_last),
      .level     (level),
      .drop_cnt  (drop_cnt),
      .line_cnt  (line_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    nm, act, exp, $time);
   endtask

   // Reference model: character queue, cycles since last push, CR phase
   logic [7:0] q[$];
   int         since_push = 0;
   bit         in_cr = 1'b0;
   int         m_drop = 0;
   int         m_line = 0;

   always @(negedge clk) begin : model
      int n;
      bit split;
      bit last;
      bit hs;
      bit pop;
      bit push;
      if (!rst_n) begin
         q.delete();
         since_push = 0;
         in_cr = 1'b0;
         m_drop = 0;
         m_line = 0;
      end
      n = q.size();
      split = CRLF && n > 0 && q[0] == 8'h0A && !in_cr;
      last = 1'b0;
      if (n > 0)
         last = !split &&
                (q[0] == 8'h0A || (since_push >= TO && n == 1));
      chk("out_valid", out_valid, n > 0);
      chk("level", level, n);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("line_cnt", line_cnt, m_line);
      if (n > 0) begin
         chk("out_ch", out_ch, split ? 8'h0D : q[0]);
         chk("out_last", out_last, last);
      end
      if (rst_n) begin
         hs = n > 0 && out_ready;
         pop = hs && !split;
         push = in_valid && (n < DEPTH || pop);
         if (hs && last && m_line < SAT) m_line++;
         if (in_valid && !push && m_drop < SAT) m_drop++;
         if (hs && split) in_cr = 1'b1;
         else if (hs) in_cr = 1'b0;
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(in_ch);
            since_push = 0;
         end else begin
            since_push++;
         end
      end
   end

   task automatic drive(input logic v, input logic [7:0] c,
                        input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_ch     = c;
      out_ready = r;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", out_valid, 0);
      chk("rst level", level, 0);
      chk("rst drop", drop_cnt, 0);
      chk("rst line", line_cnt, 0);
      chk("rst out_ch", out_ch, 0);
      chk("rst out_last", out_last, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single character, idle flush
      drive(1, 8'h41, 1);
      drive(0, 8'h00, 0);
      chk("A valid", out_valid, 1);
      chk("A ch", out_ch, 8'h41);
      chk("A last early", out_last, 0);
      repeat (TO - 1) drive(0, 8'h00, 0);
      chk("A last before timeout", out_last, 0);
      drive(0, 8'h00, 0);
      chk("A last at timeout", out_last, 1);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);
      chk("A line_cnt", line_cnt, 1);
      chk("A drained", out_valid, 0);

      // "hi\n"
      drive(1, 8'h68, 1);
      drive(1, 8'h69, 1);
      chk("hi head", out_ch, 8'h68);
      drive(1, 8'h0A, 1);
      repeat (4) drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);
      chk("hi line_cnt", line_cnt, 2);
      chk("hi drop_cnt", drop_cnt, 0);

      // overflow
      for (int i = 0; i < 20; i++) drive(1, 8'(8'h30 + i), 0);
      drive(0, 8'h00, 0);
      chk("ovf level", level, 16);
      chk("ovf drop", drop_cnt, 4);
      chk("ovf head", out_ch, 8'h30);
      drive(1, 8'h55, 1);
      drive(0, 8'h00, 0);
      chk("full+pop level", level, 16);
      chk("full+pop drop", drop_cnt, 4);
      chk("full+pop head", out_ch, 8'h31);
      repeat (5) drive(1, 8'h58, 0);
      drive(0, 8'h00, 0);
      chk("drop saturates", drop_cnt, SAT);
      repeat (18) drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);
      chk("ovf drained", level, 0);

      // mid-stream reset
      for (int i = 0; i < 8; i++) drive(1, 8'(8'h61 + i), 0);
      drive(0, 8'h00, 0);
      chk("pre-rst level", level, 8);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid-rst valid", out_valid, 0);
      chk("mid-rst level", level, 0);
      chk("mid-rst drop", drop_cnt, 0);
      chk("mid-rst line", line_cnt, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_ch = 8'h7A;
      out_ready = 1'b0;
      drive(0, 8'h00, 0);
      chk("post-rst valid", out_valid, 1);
      chk("post-rst ch", out_ch, 8'h7A);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

      // LF handling
      drive(1, 8'h0A, 0);
      drive(0, 8'h00, 0);
`ifdef UART_OUT_CRLF_EN
      chk("crlf cr ch", out_ch, 8'h0D);
      chk("crlf cr last", out_last, 0);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);
      chk("crlf lf ch", out_ch, 8'h0A);
      chk("crlf lf last", out_last, 1);
      drive(0, 8'h00, 0);
      chk("crlf lf hold", out_ch, 8'h0A);
`else
      chk("lf ch", out_ch, 8'h0A);
      chk("lf last", out_last, 1);
`endif
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);
      chk("lf line_cnt", line_cnt, 1);
      chk("lf drained", out_valid, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_out_buffer.md
Name: uart_out_buffer

Overview:
- Sits directly downstream of SimTop's UART output pins (uart out valid / uart out ch) in the simulation top.
- SimTop's UART output has no backpressure, so this block captures every character into a FIFO and presents it on a valid/ready drain interface.
- Each entry is tagged with an end-of-line marker so the host-side consumer can flush whole lines.
- Counts dropped characters and completed lines for end-of-run reporting.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- IDLE_TIMEOUT, 1024: cycles without a new character before a partial line is marked last; at least 1.
- CNT_W, 32: width of the drop and line counters.

Ports:
- clock  input  1  sole clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  character strobe from SimTop uart out valid.
- in_ch  input  8  character from SimTop uart out ch.
- out_valid  output  1  head character available.
- out_ready  input  1  consumer accepts the head character.
- out_ch  output  8  head character.
- out_last  output  1  head character ends a line (LF, or idle-timeout flush).
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  CNT_W  characters lost to overflow; saturating.
- line_cnt  output  CNT_W  accepted beats with out_last=1; saturating.

Behaviour:
- Reset values: out_valid 0, level 0, drop_cnt 0, line_cnt 0, out_ch 0, out_last 0. The idle timer, the force_last flag and the FSM state are also cleared.
- Reset is honoured mid-operation: FIFO contents are discarded immediately and asynchronously.
- Push:
  - Occurs when in_valid=1 and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the character is dropped and drop_cnt increments, holding at all-ones.
- Entry format: {ch[7:0], lf}. lf is 1 when ch==0x0A.
- Latency: a character pushed in cycle N appears at the head with out_valid=1 in cycle N+1 if the FIFO was empty. No combinational path exists from in_* to out_*.
- Pop: occurs on out_valid && out_ready, in the emit state described below.
- Ordering: FIFO order is strict. Wrap-around of the read and write pointers is by modulo DEPTH, with one extra bit used to distinguish full from empty.
- Idle timer:
  - Counts cycles with no push while the FIFO is non-empty.
  - Resets to 0 on any push, and whenever the FIFO is empty.
  - On reaching IDLE_TIMEOUT it sets force_last and stops counting.
  - force_last clears on the next push, and when the entry it applies to is popped.
- out_last = head.lf OR (force_last AND level==1).
  - force_last applies only to the most recently pushed entry.
- line_cnt increments on every handshake with out_last=1, holding at all-ones.
- Outputs must be stable: out_ch and out_last do not change while out_valid=1 and out_ready=0.
- Drain FSM:
  - EMIT: head is presented as described above.
  - CR: used only under the optional feature (see below).
  - Without the feature the FSM stays in EMIT permanently.

Optional Feature:
- Macro: UART_OUT_CRLF_EN.
- When defined, a head entry with ch==0x0A is emitted as two beats:
  - EMIT presents out_ch=0x0D with out_last=0 and no pop.
  - That handshake moves the FSM to CR.
  - CR presents 0x0A with out_last=1; its handshake pops the entry and returns the FSM to EMIT.
- Pushes continue normally while in CR.
- When undefined, 0x0A passes through as a single beat and the CR state is not built.

Decomposition:
- Package uart_buf_pkg contains:
  - CH_LF = 8'h0A and CH_CR = 8'h0D.
  - Packed struct uart_entry_t {logic [7:0] ch; logic lf;}.
  - Enum drain_state_t {EMIT, CR}.
- Sub-module sync_fifo:
  - Parameterised by DEPTH and the entry type.
  - Provides push/pop/full/empty/level and head data.
  - Same clock and asynchronous active-low reset.
- Top level holds the idle timer, force_last, the FSM and the counters.

Test Plan:
- Single character: push 'A'(0x41) with out_ready=1 -> out_valid=1 next cycle with out_ch=0x41 and out_last=0. After IDLE_TIMEOUT idle cycles with out_ready held 0, out_last=1; handshake -> line_cnt=1.
- Line: push "hi\n" on consecutive cycles with out_ready=1 -> beats 0x68, 0x69, 0x0A with out_last only on 0x0A; line_cnt=1, drop_cnt=0.
- Overflow: out_ready=0, push 20 characters with DEPTH=16 -> level=16, drop_cnt=4. The first 16 characters drain in order.
- Full with simultaneous pop: FIFO full, in_valid=1 and out_ready=1 in the same cycle -> push accepted, level stays 16, drop_cnt unchanged.
- Mid-stream reset: 8 entries buffered, reset pulled to 0 for 1 cycle -> out_valid=0, level=0, both counters 0. The next push appears one cycle later.
- CRLF (UART_OUT_CRLF_EN defined): push 0x0A -> beats 0x0D (last=0) then 0x0A (last=1). Holding out_ready=0 during CR keeps 0x0A stable; line_cnt=1.
